// File: rtl/drive_pkg.sv
// Shared types for the line-following drive sequencer: FSM states,
// motor command codes and the line-sensor decode.
package drive_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FWD    = 3'd1,
    TURN_L = 3'd2,
    TURN_R = 3'd3,
    SEARCH = 3'd4,
    HOLD   = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_FWD   = 2'b11;

  typedef enum logic [2:0] {
    DEC_FWD,
    DEC_LEFT,
    DEC_RIGHT,
    DEC_LOST,
    DEC_KEEP
  } decode_t;

  // Sensor bits are {left, mid, right}; 101 carries no steering information.
  function automatic decode_t decode_ir(input logic [2:0] ir);
    case (ir)
      3'b010, 3'b111: decode_ir = DEC_FWD;
      3'b100, 3'b110: decode_ir = DEC_LEFT;
      3'b001, 3'b011: decode_ir = DEC_RIGHT;
      3'b000:         decode_ir = DEC_LOST;
      default:        decode_ir = DEC_KEEP;
    endcase
  endfunction

endpackage

// File: rtl/ir_debounce.sv
// Two-flop synchronizer followed by a run-length debouncer: the output
// takes a new value only after DEB_CYCLES identical consecutive samples.
module ir_debounce #(
  parameter int DEB_CYCLES = 1000,
  parameter int WIDTH      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int            CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(DEB_CYCLES);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] last;
  logic [CW-1:0]    run_cnt;
  logic [CW-1:0]    run_next;

  // Length of the current run of identical samples, including this one.
  always_comb begin
    if (sync2 != last)           run_next = CW'(1);
    else if (run_cnt == RUN_MAX) run_next = RUN_MAX;
    else                         run_next = run_cnt + CW'(1);
  end

  // Synchronizer chain, run tracking and debounced output update.
  // NOTE: non-blocking assignments make each stage capture the previous
  // stage's old value, which is what turns these flops into a real chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      last    <= '0;
      run_cnt <= '0;
      dout    <= '0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      last    <= sync2;
      run_cnt <= run_next;
      if (run_next == RUN_MAX) dout <= sync2;
    end
  end

endmodule

// File: rtl/drive_sequencer.sv
// Line-following drive sequencer: debounced IR steering, turn dwell,
// lost-line search with timeout, obstacle hold and a fault halt.
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int DEB_CYCLES   = 1000,
  parameter int MIN_DWELL    = 200000,
  parameter int LOST_TIMEOUT = 50000000,
  parameter int OBST_CM      = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] ir,
  input  logic [7:0] dist_cm,
  input  logic       dist_valid,
  output logic [1:0] mode,
  output logic [2:0] state,
  output logic       fault
);

  localparam int            DW         = $clog2(MIN_DWELL) + 1;
  localparam int            SW         = $clog2(LOST_TIMEOUT) + 1;
  localparam logic [DW-1:0] DWELL_MAX  = DW'(MIN_DWELL);
  localparam logic [SW-1:0] SEARCH_MAX = SW'(LOST_TIMEOUT);
  localparam logic [7:0]    OBST_LIMIT = 8'(OBST_CM);

  state_t        cur_state;
  state_t        nxt_state;
  state_t        steer;
  decode_t       dec;
  logic [2:0]    deb_ir;
  logic [DW-1:0] dwell_cnt;
  logic [DW-1:0] dwell_inc;
  logic [SW-1:0] search_cnt;
  logic [SW-1:0] search_inc;
  logic          last_right;
  logic          last_right_nxt;
  logic [1:0]    mode_nxt;
  logic          near;
  logic          far;
  logic          running;
  logic          turning;

  ir_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .WIDTH     (3)
  ) u_ir_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ir),
    .dout (deb_ir)
  );

  assign dec        = decode_ir(deb_ir);
  assign near       = dist_valid && (dist_cm < OBST_LIMIT);
  assign far        = dist_valid && (dist_cm >= OBST_LIMIT);
  assign running    = cur_state inside {FWD, TURN_L, TURN_R, SEARCH};
  assign turning    = cur_state inside {TURN_L, TURN_R};
  assign dwell_inc  = (dwell_cnt == DWELL_MAX) ? DWELL_MAX : dwell_cnt + DW'(1);
  assign search_inc = (search_cnt == SEARCH_MAX) ? SEARCH_MAX : search_cnt + SW'(1);
  assign state      = cur_state;

  // Next state by priority: stop, obstacle, timeout, start, sensor decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    nxt_state = cur_state;
    steer     = cur_state;
    case (dec)
      DEC_FWD:   steer = FWD;
      DEC_LEFT:  steer = TURN_L;
      DEC_RIGHT: steer = TURN_R;
      DEC_LOST:  steer = SEARCH;
      default:   steer = cur_state;
    endcase

    if (stop) begin
      nxt_state = IDLE;
    end else if (running && near) begin
      nxt_state = HOLD;
    end else if (cur_state == HOLD) begin
      if (far) nxt_state = FWD;
    end else if (cur_state == SEARCH && search_inc == SEARCH_MAX) begin
      nxt_state = HALT;
    end else if (start && (cur_state == IDLE || cur_state == HALT)) begin
      nxt_state = FWD;
    end else if (turning) begin
      // Losing the line always escapes a turn; steering changes wait for dwell.
      if (steer == SEARCH || dwell_inc == DWELL_MAX) nxt_state = steer;
    end else if (running) begin
      nxt_state = steer;
    end
  end

  // Remember the last turn and decode the motor command from the next state.
  always_comb begin
    last_right_nxt = last_right;
    if (nxt_state == TURN_L)      last_right_nxt = 1'b0;
    else if (nxt_state == TURN_R) last_right_nxt = 1'b1;

    case (nxt_state)
      FWD:     mode_nxt = MODE_FWD;
      TURN_L:  mode_nxt = MODE_LEFT;
      TURN_R:  mode_nxt = MODE_RIGHT;
      SEARCH:  mode_nxt = last_right_nxt ? MODE_RIGHT : MODE_LEFT;
      default: mode_nxt = MODE_STOP;
    endcase
  end

  // State, registered outputs and the saturating dwell/search counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state  <= IDLE;
      mode       <= MODE_STOP;
      fault      <= 1'b0;
      dwell_cnt  <= '0;
      search_cnt <= '0;
      last_right <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      mode       <= mode_nxt;
      fault      <= (nxt_state == HALT);
      dwell_cnt  <= (turning && nxt_state == cur_state) ? dwell_inc : '0;
      search_cnt <= (cur_state == SEARCH && nxt_state == SEARCH) ? search_inc : '0;
      last_right <= last_right_nxt;
    end
  end

endmodule
